// File: rtl/binary_row_parser.sv
// binary_row_parser: recovers an 8-bit value from ASCII rows "Bin: bbbbbbbb   "
// arriving one character per valid beat (typically straight from a UART RX).
module binary_row_parser #(
   parameter int unsigned ROW_LEN   = 16,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_char_valid,
   input  logic [7:0]           i_char,
   output logic [7:0]           o_value,
   output logic                 o_value_valid,
   output logic                 o_error,
   output logic [ERR_CNT_W-1:0] o_err_count,
   output logic [3:0]           o_char_index
);

   localparam int unsigned IDX_W = 4;
   localparam logic [IDX_W-1:0] IDX_PREFIX_LAST = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_BITS_LAST   = IDX_W'(12);
   localparam logic [IDX_W-1:0] IDX_ROW_LAST    = IDX_W'(ROW_LEN - 1);
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_ONE   = 8'h31;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_PREFIX,
      ST_BITS,
      ST_TAIL,
      ST_DROP
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [7:0]           shreg_q, shreg_d;
   logic [7:0]           value_d;
   logic                 value_valid_d;
   logic                 error_d;
   logic [ERR_CNT_W-1:0] err_count_d;
   logic                 raise_err;
   logic [7:0]           shifted;

   // Expected prefix character at a given row position.
   function automatic logic [7:0] prefix_char(input logic [IDX_W-1:0] idx);
      case (idx)
         IDX_W'(0): prefix_char = 8'h42;   // 'B'
         IDX_W'(1): prefix_char = 8'h69;   // 'i'
         IDX_W'(2): prefix_char = 8'h6E;   // 'n'
         IDX_W'(3): prefix_char = 8'h3A;   // ':'
         default:   prefix_char = CH_SPACE;
      endcase
   endfunction

   // State and output registers; outputs take their next values from the comb block.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q       <= ST_PREFIX;
         idx_q         <= '0;
         shreg_q       <= '0;
         o_value       <= '0;
         o_value_valid <= 1'b0;
         o_error       <= 1'b0;
         o_err_count   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         shreg_q       <= shreg_d;
         o_value       <= value_d;
         o_value_valid <= value_valid_d;
         o_error       <= error_d;
         o_err_count   <= err_count_d;
      end
   end

   // Next-state and next-output decode for one received character.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      shreg_d       = shreg_q;
      value_d       = o_value;
      value_valid_d = 1'b0;
      error_d       = 1'b0;
      err_count_d   = o_err_count;
      raise_err     = 1'b0;
      shifted       = {shreg_q[6:0], i_char[0]};

      if (i_char_valid) begin
         case (state_q)
            ST_PREFIX: begin
               if (idx_q == '0 && (i_char == CH_CR || i_char == CH_LF)) begin
                  // blank lines and CRLF pairs between rows are ignored
               end else if (i_char == prefix_char(idx_q)) begin
                  idx_d = idx_q + IDX_W'(1);
                  if (idx_q == IDX_PREFIX_LAST) state_d = ST_BITS;
               end else begin
                  raise_err = 1'b1;
               end
            end
            ST_BITS: begin
               if (i_char == CH_ZERO || i_char == CH_ONE) begin
                  shreg_d = shifted;
                  if (idx_q == IDX_BITS_LAST) begin
                     value_d       = shifted;
                     value_valid_d = 1'b1;
                     if (ROW_LEN == 13) begin
                        state_d = ST_PREFIX;
                        idx_d   = '0;
                     end else begin
                        state_d = ST_TAIL;
                        idx_d   = idx_q + IDX_W'(1);
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  raise_err = 1'b1;
               end
            end
            ST_TAIL: begin
               if (i_char == CH_SPACE) begin
                  if (idx_q == IDX_ROW_LAST) begin
                     state_d = ST_PREFIX;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else if (i_char == CH_CR || i_char == CH_LF) begin
                  // value already delivered; early line end is benign
                  state_d = ST_PREFIX;
                  idx_d   = '0;
               end else begin
                  raise_err = 1'b1;
               end
            end
            default: begin
               if (i_char == CH_LF) begin
                  state_d = ST_PREFIX;
                  idx_d   = '0;
               end
            end
         endcase

         if (raise_err) begin
            error_d = 1'b1;
            if (o_err_count != ERR_CNT_MAX) err_count_d = o_err_count + ERR_CNT_W'(1);
            shreg_d = '0;
            idx_d   = '0;
            // an LF already marks the row boundary, so resync immediately
            state_d = (i_char == CH_LF) ? ST_PREFIX : ST_DROP;
         end
      end
   end

   assign o_char_index = idx_q;

endmodule

// File: tb/tb_binary_row_parser.sv
// tb_binary_row_parser: directed rows with hand-computed expected values.
module tb_binary_row_parser;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_char_valid;
   logic [7:0] i_char;
   logic [7:0] o_value;
   logic       o_value_valid;
   logic       o_error;
   logic [7:0] o_err_count;
   logic [3:0] o_char_index;

   int n_vec  = 0;
   int n_miss = 0;
   int n_vv   = 0;
   int n_errp = 0;

   binary_row_parser #(.ROW_LEN(16), .ERR_CNT_W(8)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_char_valid  (i_char_valid),
      .i_char        (i_char),
      .o_value       (o_value),
      .o_value_valid (o_value_valid),
      .o_error       (o_error),
      .o_err_count   (o_err_count),
      .o_char_index  (o_char_index)
   );

   always #5 i_clk = ~i_clk;

   // Count output pulses; a pulse stuck high is counted repeatedly.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_value_valid) n_vv++;
         if (o_error) n_errp++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One beat; returns 1 time unit after the sampling edge.
   task automatic put(input logic [7:0] c);
      i_char_valid = 1'b1;
      i_char       = c;
      @(posedge i_clk);
      #1;
      i_char_valid = 1'b0;
   endtask

   task automatic put_str(input string s);
      for (int i = 0; i < s.len(); i++) put(s[i]);
   endtask

   task automatic put_str_gap(input string s);
      for (int i = 0; i < s.len(); i++) begin
         put(s[i]);
         repeat (2) @(posedge i_clk);
         #1;
      end
   endtask

   initial begin
      i_rst        = 1'b1;
      i_char_valid = 1'b0;
      i_char       = 8'h00;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_value", 32'(o_value), 32'h00);
      check("rst_idx", 32'(o_char_index), 32'h0);
      check("rst_errcnt", 32'(o_err_count), 32'h0);
      i_rst = 1'b0;

      // T1: full row, back to back
      put_str("Bin: 10100101");
      check("t1_vv", 32'(o_value_valid), 32'h1);
      check("t1_value", 32'(o_value), 32'hA5);
      check("t1_idx13", 32'(o_char_index), 32'd13);
      put(8'h20);
      check("t1_vv_drop", 32'(o_value_valid), 32'h0);
      put_str("  ");
      check("t1_idx0", 32'(o_char_index), 32'h0);
      check("t1_noerr", 32'(o_err_count), 32'h0);

      // T2: bad bit char, DROP, then recovery with CRLF ending
      put_str("Bin: 0000000");
      put(8'h32);
      check("t2_err", 32'(o_error), 32'h1);
      check("t2_errcnt", 32'(o_err_count), 32'h1);
      check("t2_hold", 32'(o_value), 32'hA5);
      check("t2_drop_idx", 32'(o_char_index), 32'h0);
      put_str("x\n");
      check("t2_drop_noerr", 32'(o_err_count), 32'h1);
      put_str("Bin: 11111111\r\n");
      check("t2_value", 32'(o_value), 32'hFF);
      check("t2_errcnt2", 32'(o_err_count), 32'h1);
      check("t2_idx", 32'(o_char_index), 32'h0);

      // T3: blank lines and idle gaps
      put_str_gap("\r\n\r\nBin: 00000001   ");
      check("t3_value", 32'(o_value), 32'h01);
      check("t3_errcnt", 32'(o_err_count), 32'h1);
      check("t3_idx", 32'(o_char_index), 32'h0);

      // T4: prefix error, then LF mid-row resyncs without DROP
      put_str("Bim");
      check("t4_err", 32'(o_err_count), 32'h2);
      put_str("\nBin: 01\n");
      check("t4_lf_err", 32'(o_err_count), 32'h3);
      put(8'h42);
      check("t4_no_drop", 32'(o_char_index), 32'h1);
      put_str("in: 10000000   ");
      check("t4_value", 32'(o_value), 32'h80);
      check("t4_errcnt", 32'(o_err_count), 32'h3);

      // T5: asynchronous reset mid-row
      put_str("Bin: 101");
      check("t5_idx", 32'(o_char_index), 32'd8);
      #2;
      i_rst = 1'b1;
      #1;
      check("t5_value", 32'(o_value), 32'h00);
      check("t5_idx0", 32'(o_char_index), 32'h0);
      check("t5_errcnt", 32'(o_err_count), 32'h0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      put_str("Bin: 00111100   ");
      check("t5_after", 32'(o_value), 32'h3C);
      check("t5_after_err", 32'(o_err_count), 32'h0);

      // T6: error counter saturation
      for (int i = 0; i < 260; i++) begin
         put(8'h58);
         if (i == 0)   check("t6_first", 32'(o_err_count), 32'h1);
         if (i == 254) check("t6_255", 32'(o_err_count), 32'hFF);
         if (i == 259) check("t6_pulse_sat", 32'(o_error), 32'h1);
         put(8'h0A);
      end
      check("t6_sat", 32'(o_err_count), 32'hFF);
      check("t6_value_hold", 32'(o_value), 32'h3C);

      @(posedge i_clk);
      #1;
      check("vv_pulses", 32'(n_vv), 32'd5);
      check("err_pulses", 32'(n_errp), 32'd263);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
